// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS core: FSM states, opcodes, ALU ops
// and the control word that the controller hands to the datapath.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFS = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        alu_op_e    alu_op;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// Control FSM and instruction decoder. Memory-side outputs depend on the
// state register only, so mem_ready never reaches an output combinationally.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       misalign,
    output ctrl_t      ctl,
    output logic       mem_req,
    output logic       mem_we,
    output logic       halted
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    assign mem_req = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_we  = (state_q == S_MEMWR);
    assign halted  = (state_q == S_HALT);

    always_comb begin
        state_d    = state_q;
        ctl        = '0;
        ctl.alu_op = ALU_ADD;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                ctl.alu_src_b = SRCB_4;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed here, while the ALU is otherwise idle.
                ctl.alu_src_b = SRCB_BOFS;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = funct_legal(funct) ? S_EXEC : S_HALT;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                if (misalign)            state_d = S_HALT;
                else if (opcode == OP_LW) state_d = S_MEMRD;
                else                     state_d = S_MEMWR;
            end
            S_MEMRD: begin
                ctl.i_or_d = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                ctl.i_or_d = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = funct_to_alu(funct);
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALU_SUB;
                ctl.branch    = 1'b1;
                ctl.pc_src    = PC_ALUOUT;
                ctl.pc_write  = zero ^ (opcode == OP_BNE);
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PC_JUMP;
                state_d      = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: datapath around the mips_mc_ctrl FSM, with a single
// shared instruction/data port using a req/ready handshake.
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [31:0]       pc
);

    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [31:0] rf_q [32];
    logic [31:0] alu_a, alu_b, alu_y, imm_sx, addr32, wb_data;
    logic [4:0]  rs, rt, wb_reg;
    logic        zero, unused_bits;
    ctrl_t       ctl;

    mips_mc_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (ir_q[31:26]),
        .funct     (ir_q[5:0]),
        .zero      (zero),
        .mem_ready (mem_ready),
        .misalign  (|alu_y[1:0]),
        .ctl       (ctl),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted)
    );

    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        alu_a = ctl.alu_src_a ? a_q : pc_q;
        case (ctl.alu_src_b)
            SRCB_B:   alu_b = b_q;
            SRCB_4:   alu_b = 32'd4;
            SRCB_IMM: alu_b = imm_sx;
            default:  alu_b = {imm_sx[29:0], 2'b00};
        endcase
        case (ctl.alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end
    assign zero = (alu_y == 32'd0);

    // Operand and address registers freeze while a transfer is pending so the
    // bus stays stable across any number of wait states.
    always_comb begin
        pc_d = pc_q;
        if (ctl.pc_write) begin
            case (ctl.pc_src)
                PC_ALUOUT: pc_d = alu_out_q;
                PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                default:   pc_d = alu_y;
            endcase
        end
        ir_d      = ctl.ir_write ? mem_rdata : ir_q;
        a_d       = mem_req ? a_q : ((rs == 5'd0) ? 32'd0 : rf_q[rs]);
        b_d       = mem_req ? b_q : ((rt == 5'd0) ? 32'd0 : rf_q[rt]);
        alu_out_d = mem_req ? alu_out_q : alu_y;
        mdr_d     = (mem_req && mem_ready && !mem_we) ? mem_rdata : mdr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    assign wb_reg  = ctl.reg_dst ? ir_q[15:11] : rt;
    assign wb_data = ctl.mem_to_reg ? mdr_q : alu_out_q;

    always_ff @(posedge clk) begin
        if (ctl.reg_write && wb_reg != 5'd0) rf_q[wb_reg] <= wb_data;
    end

    assign addr32      = ctl.i_or_d ? alu_out_q : pc_q;
    assign mem_addr    = addr32[ADDR_W-1:0];
    assign mem_wdata   = b_q;
    assign pc          = pc_q;
    assign unused_bits = ^{ir_q[10:6], addr32, ctl.branch};

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: program table checked through
// stores to data RAM, plus hand sequences for reset, stalls, halt and abort.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc;

    always #5 clk = ~clk;

    mips_multicycle_core #(.RESET_PC(32'h100), .ADDR_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc        (pc)
    );

    // Program ROM above 0x100, data RAM below it.
    logic [31:0] rom [0:1023];
    logic [31:0] ram [0:63];
    int wait_n = 0;
    int stall_cnt;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      stall_cnt <= 0;
        else if (mem_req && !mem_ready)  stall_cnt <= stall_cnt + 1;
        else                             stall_cnt <= 0;
    end

    assign mem_ready = (wait_n == 0) ? 1'b1 : (mem_req && stall_cnt >= wait_n);
    assign mem_rdata = (mem_addr < 12'h100) ? ram[mem_addr[7:2]] : rom[mem_addr[11:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hDEAD_BEEF;
        end else if (mem_req && mem_ready && mem_we && mem_addr < 12'h100) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // Transfer log: start cycle and attributes of each request, plus a count
    // of cycles where the bus changed before completion.
    int          xs_cyc[$];
    logic [11:0] xs_addr[$];
    logic        xs_we[$];
    logic [31:0] xs_wd[$];
    logic        in_xfer = 1'b0;
    logic [11:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_wd;
    int          unstable = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_xfer = 1'b0;
            unstable = 0;
            xs_cyc.delete(); xs_addr.delete(); xs_we.delete(); xs_wd.delete();
        end else if (mem_req) begin
            if (!in_xfer) begin
                xs_cyc.push_back(cyc); xs_addr.push_back(mem_addr);
                xs_we.push_back(mem_we); xs_wd.push_back(mem_wdata);
                cur_addr = mem_addr; cur_we = mem_we; cur_wd = mem_wdata;
                in_xfer = 1'b1;
            end else if (mem_addr !== cur_addr || mem_we !== cur_we || mem_wdata !== cur_wd) begin
                unstable++;
            end
            if (mem_ready) in_xfer = 1'b0;
        end else begin
            in_xfer = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input int id);
        logic [31:0] p[$];
        for (int i = 0; i < 1024; i++) rom[i] = 32'hFC00_0000;
        case (id)
            0: p = '{32'h20010005, 32'h2002FFFD, 32'h00221820, 32'h0041202A,
                     32'hAC030008, 32'h8C050008, 32'hAC05000C, 32'hAC040010};
            1: p = '{32'h20010007, 32'h20020007, 32'h20030055, 32'h10220002,
                     32'h20030001, 32'h20030002, 32'h14220001, 32'h20040009,
                     32'h20000005, 32'hAC000014, 32'hAC030018, 32'hAC04001C,
                     32'h08000050, 32'hAC010020};
            2: begin rom[68] = 32'h08000040; p = '{32'h08000044}; end
            4: p = '{32'h8C010006};
            5: p = '{32'h20010FF0, 32'h200200FF, 32'h00221824, 32'h00222025,
                     32'h00412822, 32'h0022302A, 32'hAC030024, 32'hAC040028,
                     32'hAC05002C, 32'hAC060030};
            default: p = '{};
        endcase
        foreach (p[i]) rom[64+i] = p[i];
    endtask

    task automatic do_reset(input int w);
        rst_n = 1'b0;
        wait_n = w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        for (int n = 0; n < 3000 && !halted; n++) begin
            @(posedge clk); #1;
        end
        check({name, "_halt"}, halted, 1'b1);
    endtask

    typedef struct {
        string       name;
        int          prog;
        int          waits;
        int          addr;
        logic [31:0] exp;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string n, input int p, input int w, input int a,
                           input logic [31:0] e, input logic [31:0] epc);
        vec_t v;
        v.name = n; v.prog = p; v.waits = w; v.addr = a; v.exp = e; v.exp_pc = epc;
        vecs.push_back(v);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int reqs;
        add_vec("add_sw",  0, 0,  8, 32'h2,         32'h124);
        add_vec("lw",      0, 0, 12, 32'h2,         32'h124);
        add_vec("slt_neg", 0, 0, 16, 32'h1,         32'h124);
        add_vec("lw_ws",   0, 3, 12, 32'h2,         32'h124);
        add_vec("r0",      1, 0, 20, 32'h0,         32'h144);
        add_vec("beq",     1, 0, 24, 32'h55,        32'h144);
        add_vec("bne",     1, 0, 28, 32'h9,         32'h144);
        add_vec("j_skip",  1, 0, 32, 32'hDEADBEEF,  32'h144);
        add_vec("beq_ws",  1, 2, 24, 32'h55,        32'h144);
        add_vec("and",     5, 0, 36, 32'h0F0,       32'h12C);
        add_vec("or",      5, 0, 40, 32'hFFF,       32'h12C);
        add_vec("sub",     5, 0, 44, 32'hFFFFF10F,  32'h12C);
        add_vec("slt_pos", 5, 1, 48, 32'h0,         32'h12C);

        // Reset vector, first fetch timing and zero-wait CPI.
        load(0);
        rst_n = 1'b0; wait_n = 0;
        repeat (3) @(posedge clk); #1;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 32'h100);
        @(negedge clk); rst_n = 1'b1; #1;
        check("cycle1_req", mem_req, 0);
        @(posedge clk); #1;
        check("fetch0_req", mem_req, 1);
        check("fetch0_addr", mem_addr, 12'h100);
        check("fetch0_we", mem_we, 0);
        wait_halt("p0");
        check("p0_xfers", xs_cyc.size(), 13);
        check("p0_cpi_total", xs_cyc[8] - xs_cyc[0], 25);
        check("p0_sw_cpi", xs_cyc[6] - xs_cyc[4], 4);
        check("p0_lw_cpi", xs_cyc[8] - xs_cyc[6], 5);
        check("p0_sw_addr", xs_addr[5], 12'h008);
        check("p0_sw_we", xs_we[5], 1);
        check("p0_sw_data", xs_wd[5], 32'h2);

        // Three wait states on every transfer.
        do_reset(3);
        wait_halt("ws");
        check("ws_stable", unstable, 0);
        check("ws_xfers", xs_cyc.size(), 13);
        check("ws_addi_cpi", xs_cyc[1] - xs_cyc[0], 7);
        check("ws_sw_cpi", xs_cyc[6] - xs_cyc[4], 10);
        check("ws_lw_cpi", xs_cyc[8] - xs_cyc[6], 11);
        check("ws_sw_data", xs_wd[5], 32'h2);

        foreach (vecs[i]) begin
            load(vecs[i].prog);
            do_reset(vecs[i].waits);
            wait_halt(vecs[i].name);
            check(vecs[i].name, ram[vecs[i].addr >> 2], vecs[i].exp);
            check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
        end

        // j 0x44 then j 0x40 back to the reset vector.
        load(2);
        do_reset(0);
        for (int n = 0; n < 50 && xs_cyc.size() < 3; n++) @(posedge clk);
        #1;
        check("j_xfers", xs_cyc.size() >= 3, 1);
        check("j_first", xs_addr[1], 12'h110);
        check("j_back", xs_addr[2], 12'h100);
        check("j_cpi", xs_cyc[1] - xs_cyc[0], 3);

        // Illegal opcode: halted right after DECODE, bus stays quiet.
        load(3);
        do_reset(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ill_decode_halted", halted, 0);
        @(posedge clk); #1;
        check("ill_halted", halted, 1);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        check("ill_quiet", reqs, 0);
        check("ill_pc", pc, 32'h104);
        check("ill_xfers", xs_cyc.size(), 1);

        // Misaligned lw halts without a data request.
        load(4);
        do_reset(0);
        wait_halt("mis");
        check("mis_xfers", xs_cyc.size(), 1);
        check("mis_req", mem_req, 0);

        // Reset while FETCH is stalled, then a clean rerun.
        load(0);
        do_reset(1000);
        @(posedge clk); #1;
        check("ab_req_before", mem_req, 1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ab_req_drop", mem_req, 0);
        check("ab_pc", pc, 32'h100);
        do_reset(0);
        wait_halt("ab_rerun");
        check("ab_rerun_sw", ram[2], 32'h2);
        check("ab_rerun_pc", pc, 32'h124);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
